mem_port_arbiter: RTL

//  Shares one stalling 16-bit memory (Rd/Wr/Done/Stall/err interface) between the instruction-fetch port (read-only)
//  and the data-memory port (read/write) of the single-memory processor configuration. Locks ownership from the

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one stalling memory between fetch and data ports
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_done,
    output logic              i_stall,
    output logic              i_err,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_done,
    output logic              d_stall,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_err
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STARVE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_I = 2'd1;
    localparam logic [1:0] OWN_D = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;

    logic d_req;
    logic d_both;
    logic starved;
    logic grant_i;
    logic grant_d;
    logic fwd_d;
    logic d_bad_done;
    logic i_complete;
    logic d_complete;
    logic mem_unused;

    // The memory's own stall is implied by the absence of mem_done.
    assign mem_unused = mem_stall;

    // Pick the port that drives the memory this cycle; an owner keeps the memory until done or until it drops its request.
    always_comb begin
        d_req   = d_rd | d_wr;
        d_both  = d_rd & d_wr;
        starved = i_rd && (starve_cnt == MAX_CNT);
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            case (state)
                OWN_I:   grant_i = i_rd;
                OWN_D:   grant_d = d_req;
                default: begin
                    grant_d = d_req && !starved;
                    grant_i = !grant_d && i_rd;
                end
            endcase
        end
        // A simultaneous read+write is rejected on the spot and never reaches memory.
        fwd_d      = grant_d & ~d_both;
        d_bad_done = d_both & ~rst;
        i_complete = grant_i & mem_done;
        d_complete = fwd_d & mem_done;
    end

    // Memory-side drive taken from the granted port only.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        if (fwd_d) begin
            mem_addr    = d_addr;
            mem_data_in = d_data_in;
            mem_rd      = d_rd;
            mem_wr      = d_wr;
        end else if (grant_i) begin
            mem_addr = i_addr;
            mem_rd   = 1'b1;
        end
    end

    // Port-side responses: owner sees the memory, any other pending requester stalls.
    always_comb begin
        i_done     = i_complete;
        i_err      = i_complete & mem_err;
        i_stall    = i_rd & ~i_complete;
        i_data_out = i_complete ? mem_data_out : '0;
        d_done     = d_complete | d_bad_done;
        d_err      = (d_complete & mem_err) | d_bad_done;
        d_stall    = d_req & ~(d_complete | d_bad_done);
        d_data_out = (d_complete && d_rd) ? mem_data_out : '0;
    end

    // Ownership tracking and fetch starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            if (fwd_d && !mem_done) begin
                state <= OWN_D;
            end else if (grant_i && !mem_done) begin
                state <= OWN_I;
            end else begin
                state <= IDLE;
            end
            if (!i_rd || i_complete) begin
                starve_cnt <= '0;
            end else if (d_complete && starve_cnt != MAX_CNT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
